// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared data width and data-memory responder state encoding
package cpu_mem_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response handshake between the DM stage and the data memory
interface dmem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int AW = 32
);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word store, synchronous write and registered read; contents survive reset
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // write when enabled, read port re-registers the addressed word every cycle
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder that answers one load/store at a time after WAIT_CYCLES wait states
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave io_dm
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be within 0..255");
    end

    dm_state_t     r_state, w_state_nx;
    logic [7:0]    r_cnt, w_cnt_nx;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rdata;
    logic          w_accept;
    logic          w_acc;
    logic          w_rsp_fire;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_in_range;
    logic [DW-1:0] w_arr_rdata;

    // In IDLE the live request is used so a zero-wait access can happen at the acceptance edge
    assign w_sel_we    = (r_state == DM_IDLE) ? io_dm.req_we    : r_we;
    assign w_sel_addr  = (r_state == DM_IDLE) ? io_dm.req_addr  : r_addr;
    assign w_sel_wdata = (r_state == DM_IDLE) ? io_dm.req_wdata : r_wdata;
    assign w_in_range  = w_sel_addr < AW'(DEPTH);
    assign w_accept    = (r_state == DM_IDLE) && io_dm.req_valid;
    assign w_acc       = (WAIT_CYCLES == 0) ? w_accept : (r_state == DM_WAIT) && (r_cnt == 8'd0);
    assign w_rsp_fire  = (r_state == DM_RESP) && r_rsp_valid && io_dm.rsp_ready;

    dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk     (clk),
        .i_we    (w_acc && w_sel_we && w_in_range),
        .i_addr  (w_sel_addr[IW-1:0]),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_arr_rdata)
    );

    // next state and wait counter
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            DM_IDLE: if (w_accept) begin
                w_state_nx = (WAIT_CYCLES == 0) ? DM_RESP : DM_WAIT;
                w_cnt_nx   = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);
            end
            DM_WAIT: if (r_cnt == 8'd0) w_state_nx = DM_RESP;
                     else w_cnt_nx = r_cnt - 8'd1;
            DM_RESP: if (w_rsp_fire) w_state_nx = DM_IDLE;
            default: w_state_nx = DM_IDLE;
        endcase
    end

    // state, request latch and response registers; rsp_valid rises on the first RESP edge once the registered read has settled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= DM_IDLE;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_rsp_valid <= (r_state == DM_RESP) && !w_rsp_fire;
            if (w_accept) begin
                r_we    <= io_dm.req_we;
                r_addr  <= io_dm.req_addr;
                r_wdata <= io_dm.req_wdata;
            end
            if (w_acc) r_err <= !w_in_range;
            if (r_state == DM_RESP && !r_rsp_valid) r_rdata <= (r_we || r_err) ? '0 : w_arr_rdata;
        end
    end

    assign io_dm.req_ready = r_state == DM_IDLE;
    assign io_dm.busy      = r_state != DM_IDLE;
    assign io_dm.rsp_valid = r_rsp_valid;
    assign io_dm.rsp_rdata = r_rdata;
    assign io_dm.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a 2-wait-state and a zero-wait responder sharing one stimulus source
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        t_valid = 1'b0, t_we = 1'b0, t_rdy = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    int          checks = 0, errors = 0, edges = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    dmem_responder_if #(.AW(32)) bus ();
    dmem_responder_if #(.AW(32)) bus0 ();

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .AW(32)) dut  (.clk(clk), .reset(reset), .io_dm(bus.slave));
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .AW(32)) dut0 (.clk(clk), .reset(reset), .io_dm(bus0.slave));

    assign bus.req_valid  = t_valid & ~sel;
    assign bus0.req_valid = t_valid & sel;
    assign bus.req_we     = t_we;
    assign bus0.req_we    = t_we;
    assign bus.req_addr   = t_addr;
    assign bus0.req_addr  = t_addr;
    assign bus.req_wdata  = t_wdata;
    assign bus0.req_wdata = t_wdata;
    assign bus.rsp_ready  = t_rdy;
    assign bus0.rsp_ready = t_rdy;

    wire        o_ready = sel ? bus0.req_ready : bus.req_ready;
    wire        o_valid = sel ? bus0.rsp_valid : bus.rsp_valid;
    wire [31:0] o_rdata = sel ? bus0.rsp_rdata : bus.rsp_rdata;
    wire        o_err   = sel ? bus0.rsp_err   : bus.rsp_err;
    wire        o_busy  = sel ? bus0.busy      : bus.busy;

    // issue one request, wait for acceptance, then count edges after acceptance until rsp_valid
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int acc_edge, output int lat, output logic busy_ok);
        logic rdy = 1'b0;
        int   n = 0;
        t_we = we; t_addr = addr; t_wdata = wdata; t_valid = 1'b1;
        while (!rdy && n < 20) begin
            rdy = o_ready;
            @(negedge clk);
            n++;
        end
        t_valid = 1'b0;
        acc_edge = edges;
        busy_ok = 1'b1;
        lat = 0;
        if (!rdy) begin
            lat = -1;
            return;
        end
        while (!o_valid && lat < 20) begin
            if (!o_busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!o_busy) busy_ok = 1'b0;
    endtask

    task automatic consume();
        t_rdy = 1'b1;
        @(negedge clk);
        t_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", o_rdata); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_store();
        int a, l; logic b;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", o_ready); end
        txn(1'b1, 32'd5, 32'hDEADBEEF, a, l, b);
        checks++; if (l !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", l); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL store_busy_span got %b exp 1", b); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", o_rdata); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", o_err); end
        consume();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL store_valid_drop got %b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL store_busy_drop got %b exp 0", o_busy); end
    endtask

    task automatic test_load_hold();
        int a, l, h0; logic b;
        txn(1'b0, 32'd5, 32'h0, a, l, b);
        checks++; if (l !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", l); end
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", o_rdata); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, o_valid); end
            checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rdata[%0d] got %h exp deadbeef", i, o_rdata); end
        end
        h0 = edges;
        consume();
        txn(1'b0, 32'd5, 32'h0, a, l, b);
        checks++; if (a !== h0 + 2) begin errors++; $display("FAIL release_to_accept got %0d exp %0d", a - h0, 2); end
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_rdata got %h exp deadbeef", o_rdata); end
        consume();
    endtask

    task automatic test_out_of_range();
        int a, l; logic b;
        txn(1'b1, 32'd0, 32'h11110000, a, l, b);
        consume();
        txn(1'b1, 32'd256, 32'h1, a, l, b);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", o_err); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", o_rdata); end
        consume();
        txn(1'b0, 32'd0, 32'h0, a, l, b);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL oor_next_err got %b exp 0", o_err); end
        checks++; if (o_rdata !== 32'h11110000) begin errors++; $display("FAIL oor_addr0 got %h exp 11110000", o_rdata); end
        consume();
        txn(1'b0, 32'hFFFF_0003, 32'h0, a, l, b);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL oor_high_err got %b exp 1", o_err); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL oor_high_rdata got %h exp 0", o_rdata); end
        consume();
    endtask

    task automatic test_wait0();
        int a, l, a0; logic b;
        sel = 1'b1;
        txn(1'b1, 32'd7, 32'h12345678, a0, l, b);
        checks++; if (l !== 1) begin errors++; $display("FAIL w0_store_latency got %0d exp 1", l); end
        consume();
        txn(1'b0, 32'd7, 32'h0, a, l, b);
        checks++; if (l !== 1) begin errors++; $display("FAIL w0_load_latency got %0d exp 1", l); end
        checks++; if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL w0_load_rdata got %h exp 12345678", o_rdata); end
        checks++; if (a - a0 !== 3) begin errors++; $display("FAIL w0_spacing got %0d exp 3", a - a0); end
        consume();
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int a, l; logic b;
        txn(1'b1, 32'd9, 32'h99990001, a, l, b);
        consume();
        t_we = 1'b1; t_addr = 32'd9; t_wdata = 32'hAAAA5555; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_accepted_busy got %b exp 1", o_busy); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", o_busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp[%0d] got %b exp 0", i, o_valid); end
            @(negedge clk);
        end
        txn(1'b0, 32'd9, 32'h0, a, l, b);
        checks++; if (o_rdata !== 32'h99990001) begin errors++; $display("FAIL mid_store_dropped got %h exp 99990001", o_rdata); end
        consume();
    endtask

    task automatic test_back_to_back();
        int a, l, prev; logic b;
        logic [31:0] d;
        t_rdy = 1'b1;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            d = 32'hC0DE0000 + 32'(i) * 32'h111;
            txn(1'b1, 32'(i), d, a, l, b);
            if (prev >= 0) begin
                checks++; if (a - prev !== 5) begin errors++; $display("FAIL b2b_spacing_st[%0d] got %0d exp 5", i, a - prev); end
            end
            prev = a;
            txn(1'b0, 32'(i), 32'h0, a, l, b);
            checks++; if (a - prev !== 5) begin errors++; $display("FAIL b2b_spacing_ld[%0d] got %0d exp 5", i, a - prev); end
            checks++; if (o_rdata !== d) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, o_rdata, d); end
            prev = a;
        end
        @(negedge clk);
        t_rdy = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store();
        test_load_hold();
        test_out_of_range();
        test_wait0();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
